// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: CSR byte/word writes feed a circular byte FIFO
// that an 8N1 serialiser drains at one bit per CmpVal clock cycles.
module uart_tx_sched #(
   parameter int          QueueSize = 256,
   parameter int          DataWidth = 8,
   parameter int          CmpVal    = 173,
   parameter logic [11:0] WordAddr  = 12'h050,
   parameter logic [11:0] ByteAddr  = 12'h051
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         csr_enable,
   input  logic [11:0]                  csr_addr,
   input  logic [31:0]                  csr_data,
   output logic                         csr_ready,
   output logic                         tx,
   output logic                         tx_busy,
   output logic [$clog2(QueueSize):0]   fifo_count,
   output logic                         overflow
);

   localparam int PtrW  = $clog2(QueueSize);
   localparam int CntW  = PtrW + 1;
   localparam int BaudW = $clog2(CmpVal);
   localparam int IdxW  = $clog2(DataWidth);

   typedef enum logic [1:0] {Idle, Start, Data, Stop} txState_t;

   logic [DataWidth-1:0] mem_q [QueueSize];
   logic [PtrW-1:0]      rdPtr_q, wrPtr_q;
   logic [CntW-1:0]      count_q, count_d;
   logic [1:0]           pend_q;
   logic [23:0]          word_q;
   logic                 overflow_q;

   txState_t             state_q;
   logic [BaudW-1:0]     baud_q;
   logic [IdxW-1:0]      idx_q;
   logic [DataWidth-1:0] shift_q;
   logic                 tx_q;

   logic                 byteWr, wordWr, byteOk, wordOk, push, pop, drop, baudLast;
   logic [CntW:0]        reserved;
   logic [DataWidth-1:0] pushData;

   // Word acceptance reserves four slots up front, so pending sequencer bytes
   // count against free space alongside the stored bytes.
   always_comb begin
      byteWr   = csr_enable && csr_ready && (csr_addr == ByteAddr);
      wordWr   = csr_enable && csr_ready && (csr_addr == WordAddr);
      reserved = {1'b0, count_q} + {{(CntW-1){1'b0}}, pend_q};
      byteOk   = count_q < CntW'(QueueSize);
      wordOk   = reserved <= (CntW+1)'(QueueSize - 4);
      push     = (byteWr && byteOk) || (wordWr && wordOk) || (pend_q != 2'd0);
      drop     = (byteWr && !byteOk) || (wordWr && !wordOk);
      pushData = (pend_q != 2'd0) ? DataWidth'(word_q[7:0]) : DataWidth'(csr_data[7:0]);
      pop      = (state_q == Idle) && (count_q != '0);
      count_d  = count_q + CntW'(push) - CntW'(pop);
      baudLast = baud_q == BaudW'(CmpVal - 1);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= pushData;
   end

   // Push side: pointers, occupancy, overflow pulse and the word-splitting sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         pend_q     <= 2'd0;
         word_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + 1'b1;
         if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
         count_q    <= count_d;
         overflow_q <= drop;
         if (wordWr && wordOk) begin
            pend_q <= 2'd3;
            word_q <= csr_data[31:8];
         end else if (pend_q != 2'd0) begin
            pend_q <= pend_q - 2'd1;
            word_q <= word_q >> 8;
         end
      end
   end

   // Serialiser: tx is registered alongside the state, the shift register
   // moves right so the next data bit is always at bit 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= Idle;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         case (state_q)
            Idle: begin
               tx_q   <= 1'b1;
               baud_q <= '0;
               if (count_q != '0) begin
                  shift_q <= mem_q[rdPtr_q];
                  state_q <= Start;
                  tx_q    <= 1'b0;
               end
            end
            Start: begin
               if (baudLast) begin
                  baud_q  <= '0;
                  idx_q   <= '0;
                  state_q <= Data;
                  tx_q    <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            Data: begin
               if (baudLast) begin
                  baud_q <= '0;
                  if (idx_q == IdxW'(DataWidth - 1)) begin
                     state_q <= Stop;
                     tx_q    <= 1'b1;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            Stop: begin
               if (baudLast) begin
                  baud_q  <= '0;
                  state_q <= Idle;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= Idle;
         endcase
      end
   end

   assign csr_ready  = (pend_q == 2'd0);
   assign tx         = tx_q;
   assign tx_busy    = (state_q != Idle);
   assign fifo_count = count_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit-side controller for the UART peripheral.
- Accepts CSR writes to the FIFO word address (0x50) and the FIFO byte address (0x51), and serialises accepted data into a 256-entry byte FIFO.
- Drains the FIFO through an 8N1 transmitter paced by a baud compare counter.
- Sits between the core's CSR write port and the UART TX pin; sequences both the push side (word-to-byte splitting) and the pop side (frame generation).

Parameters:
- QueueSize, 256, FIFO depth in bytes; power of two ≥ 4.
- DataWidth, 8, FIFO entry width in bits.
- CmpVal, 173, clock cycles per UART bit (20 MHz / 115200 baud); ≥ 2.
- WordAddr, 12'h050, CSR address for a 4-byte push.
- ByteAddr, 12'h051, CSR address for a 1-byte push.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- csr_enable  in  1  CSR write strobe, valid for one cycle
- csr_addr  in  12  CSR address
- csr_data  in  32  CSR write data
- csr_ready  out  1  high when a new CSR write can be accepted; the core stalls while low
- tx  out  1  UART serial output, idle high
- tx_busy  out  1  high while a frame is on the line
- fifo_count  out  $clog2(QueueSize)+1  number of bytes stored
- overflow  out  1  one-cycle pulse when a write is dropped for lack of space

Behaviour:
- Reset values: tx=1, tx_busy=0, fifo_count=0, csr_ready=1, overflow=0. Pointers, baud counter, bit index and push sequencer are all cleared.
- Reset mid-frame aborts the frame: tx returns high on the next cycle and FIFO contents are discarded.
- Write acceptance: csr_enable && csr_ready && address matches. Other addresses are ignored with no side effects.
- Byte write (ByteAddr): csr_data[7:0] is pushed in the same cycle if fifo_count < QueueSize; otherwise it is dropped and overflow pulses the next cycle.
- Word write (WordAddr): accepted only if free space ≥ 4 (free = QueueSize − fifo_count − bytes still pending from a word push). Otherwise the whole word is dropped and overflow pulses; a partial push never happens.
- Word push sequencer, on acceptance:
  - latches csr_data and pushes bytes [7:0], [15:8], [23:16], [31:24] on four consecutive cycles, starting in the accept cycle;
  - drives csr_ready=0 for the three cycles after acceptance, then 1;
  - because space was reserved at acceptance, a concurrent pop never causes loss.
- FIFO: circular, read/write pointers of $clog2(QueueSize) bits wrap modulo QueueSize. Full when count == QueueSize, empty when count == 0. A simultaneous push and pop leaves the count unchanged.
- TX state machine:
  - IDLE: tx=1. If count > 0, pop the head into the shift register and go to START. The pop and the START entry happen in the same cycle.
  - START: tx=0 for CmpVal cycles.
  - DATA: 8 bits, LSB first, CmpVal cycles each; the bit index runs 0..7.
  - STOP: tx=1 for CmpVal cycles, then go to IDLE.
  - Back-to-back: if the FIFO is non-empty when STOP ends, the next START begins on the following cycle, so there is exactly one IDLE cycle between frames.
- Baud counter: counts 0..CmpVal−1, resets on each state or bit change; a bit advances when the counter equals CmpVal−1. Frame length = 10·CmpVal cycles plus the one IDLE cycle.
- tx_busy = (state != IDLE).
- A push into an empty FIFO is visible to IDLE one cycle later: first START begins 1 cycle after the push cycle.

Test Plan:
- CmpVal=4. Byte write 0x55 at t0 → fifo_count=1 at t0+1, tx falls at t0+1, bits 1,0,1,0,1,0,1,0 each 4 cycles wide, stop high, tx_busy low after 40 cycles.
- Word write 0x44332211 → csr_ready low for 3 cycles, fifo_count peaks at 4 (minus pops), tx emits 0x11, 0x22, 0x33, 0x44 in order with 1 idle cycle between frames.
- Fill with 256 byte writes while TX is stalled mid-frame (large CmpVal) → fifo_count=256; the 257th byte write gives overflow=1 for one cycle and count stays 256.
- fifo_count=253, word write → dropped, overflow pulse, count unchanged. Repeat at count=252 → accepted, count reaches 256.
- Wrap-around: push and drain 300 bytes with incrementing values → received sequence matches exactly, with no loss across the pointer wrap.
- Assert reset during DATA bit 3 → tx=1 and fifo_count=0 the next cycle; a subsequent byte write transmits a clean frame.
